// File: rtl/axis_pixels_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow beats into one wide beat.
// A partial group is flushed on tlast; the output stage is a single register.
module axis_pixels_upsizer #(
    parameter int WORD_WIDTH = 8,
    parameter int S_WORDS    = 8,
    parameter int M_WORDS    = 32
) (
    input  logic                            aclk,
    input  logic                            areset,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    input  logic [S_WORDS*WORD_WIDTH-1:0]   s_axis_tdata,
    input  logic [S_WORDS-1:0]              s_axis_tkeep,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    output logic [M_WORDS*WORD_WIDTH-1:0]   m_axis_tdata,
    output logic [M_WORDS-1:0]              m_axis_tkeep
);

    localparam int RATIO      = M_WORDS / S_WORDS;
    localparam int BITS_RATIO = $clog2(RATIO);
    localparam int SD         = S_WORDS * WORD_WIDTH;
    localparam int MD         = M_WORDS * WORD_WIDTH;

    localparam logic [BITS_RATIO-1:0] LAST_LANE = BITS_RATIO'(RATIO - 1);

    logic [BITS_RATIO-1:0] r_cnt;
    logic [MD-1:0]         r_asm_data;
    logic [M_WORDS-1:0]    r_asm_keep;
    logic                  r_m_valid;
    logic                  r_m_last;
    logic [MD-1:0]         r_m_data;
    logic [M_WORDS-1:0]    r_m_keep;

    logic                  w_s_ready;
    logic                  w_accept;
    logic                  w_close;
    logic                  w_m_xfer;
    logic [MD-1:0]         w_mrg_data;
    logic [M_WORDS-1:0]    w_mrg_keep;

    // Input may advance whenever the output register is empty or draining.
    assign w_s_ready = !r_m_valid || m_axis_tready;
    assign w_accept  = s_axis_tvalid && w_s_ready;
    assign w_m_xfer  = r_m_valid && m_axis_tready;
    assign w_close   = w_accept && ((r_cnt == LAST_LANE) || s_axis_tlast);

    // Drop the incoming beat into lane r_cnt; lanes above stay zero
    // because the assembly register is cleared after every group.
    always_comb begin
        w_mrg_data = r_asm_data;
        w_mrg_keep = r_asm_keep;
        for (int i = 0; i < RATIO; i++) begin
            if (r_cnt == BITS_RATIO'(i)) begin
                w_mrg_data[i*SD +: SD]           = s_axis_tdata;
                w_mrg_keep[i*S_WORDS +: S_WORDS] = s_axis_tkeep;
            end
        end
    end

    // Lane counter and assembly buffer for the group being built.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_cnt      <= '0;
            r_asm_data <= '0;
            r_asm_keep <= '0;
        end else if (w_close) begin
            r_cnt      <= '0;
            r_asm_data <= '0;
            r_asm_keep <= '0;
        end else if (w_accept) begin
            r_cnt      <= r_cnt + 1'b1;
            r_asm_data <= w_mrg_data;
            r_asm_keep <= w_mrg_keep;
        end
    end

    // Output register: load on a closing beat, otherwise drop valid
    // once the current word has been taken.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
        end else if (w_close) begin
            r_m_valid <= 1'b1;
            r_m_last  <= s_axis_tlast;
            r_m_data  <= w_mrg_data;
            r_m_keep  <= w_mrg_keep;
        end else if (w_m_xfer) begin
            r_m_valid <= 1'b0;
        end
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tlast  = r_m_last;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tkeep  = r_m_keep;

endmodule

// File: tb/tb_axis_pixels_upsizer.sv
// Scoreboard bench for axis_pixels_upsizer: a packet-level model predicts
// wide beats; a monitor compares every output transfer against it.
module tb_axis_pixels_upsizer;

    localparam int W  = 8;
    localparam int SW = 8;
    localparam int MW = 32;
    localparam int R  = MW / SW;
    localparam int SD = SW * W;
    localparam int MD = MW * W;

    typedef struct {
        logic [SD-1:0] d;
        logic [SW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct {
        logic [MD-1:0] d;
        logic [MW-1:0] k;
        logic          l;
    } exp_t;

    logic          aclk;
    logic          areset;
    logic          s_tready;
    logic          s_tvalid;
    logic          s_tlast;
    logic [SD-1:0] s_tdata;
    logic [SW-1:0] s_tkeep;
    logic          m_tready;
    logic          m_tvalid;
    logic          m_tlast;
    logic [MD-1:0] m_tdata;
    logic [MW-1:0] m_tkeep;

    axis_pixels_upsizer #(
        .WORD_WIDTH (W),
        .S_WORDS    (SW),
        .M_WORDS    (MW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tready (s_tready),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .m_axis_tready (m_tready),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;
    int    out_cnt = 0;
    int    last_cnt = 0;
    int    close_cyc = -10;
    int    stall_waits = 0;
    logic  rand_ready_en = 1'b0;
    beat_t grp[$];
    exp_t  exp_q[$];

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [MD-1:0] act,
                       input logic [MD-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: collect a group of beats, emit when full or on tlast.
    function automatic void model_accept(input beat_t b);
        exp_t e;
        grp.push_back(b);
        if (b.l || grp.size() == R) begin
            e.d = '0;
            e.k = '0;
            e.l = b.l;
            foreach (grp[i]) begin
                e.d[i*SD +: SD] = grp[i].d;
                e.k[i*SW +: SW] = grp[i].k;
            end
            exp_q.push_back(e);
            grp.delete();
            close_cyc = cyc;
        end
    endfunction

    function automatic logic [SD-1:0] seq(input int base);
        logic [SD-1:0] v;
        for (int i = 0; i < SW; i++) v[i*W +: W] = 8'(base + i);
        return v;
    endfunction

    function automatic logic [SD-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic send(input logic [SD-1:0] d, input logic [SW-1:0] k,
                        input logic l);
        int    t;
        beat_t b;
        t = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        forever begin
            @(negedge aclk);
            if (s_tready) begin
                b.d = d;
                b.k = k;
                b.l = l;
                model_accept(b);
                break;
            end
            stall_waits++;
            t++;
            if (t > 500) begin
                tests++;
                fails++;
                $display("FAIL send_timeout actual=stalled required=accept");
                break;
            end
        end
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge aclk);
            t++;
        end
        #1;
        chk("drain_left", MD'(exp_q.size()), '0);
    endtask

    // Monitor: scoreboard pop, hold stability, latency and ready rule.
    logic          prev_stall = 1'b0;
    logic [MD-1:0] prev_d;
    logic [MW-1:0] prev_k;
    logic          prev_l;
    exp_t          e_mon;

    always @(negedge aclk) begin
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", MD'(m_tvalid), MD'(1'b1));
                chk("hold_data", m_tdata, prev_d);
                chk("hold_keep", MD'(m_tkeep), MD'(prev_k));
                chk("hold_last", MD'(m_tlast), MD'(prev_l));
            end
            if (cyc == close_cyc + 1) begin
                chk("latency_valid", MD'(m_tvalid), MD'(1'b1));
                if (exp_q.size() != 0)
                    chk("latency_data", m_tdata, exp_q[0].d);
            end
            chk("s_ready_rule", MD'(s_tready),
                MD'(!m_tvalid || m_tready));
            if (m_tvalid && m_tready) begin
                out_cnt++;
                if (m_tlast) last_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_output actual=%h required=none",
                             m_tdata);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("out_data", m_tdata, e_mon.d);
                    chk("out_keep", MD'(m_tkeep), MD'(e_mon.k));
                    chk("out_last", MD'(m_tlast), MD'(e_mon.l));
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d = m_tdata;
            prev_k = m_tkeep;
            prev_l = m_tlast;
        end
    end

    always @(posedge aclk) begin
        if (rand_ready_en) begin
            #1;
            m_tready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic do_reset();
        areset = 1'b1;
        grp.delete();
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    int o0;
    int l0;
    int t;

    initial begin
        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        m_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;

        chk("rst_s_ready", MD'(s_tready), MD'(1'b1));
        chk("rst_m_valid", MD'(m_tvalid), '0);
        chk("rst_m_last", MD'(m_tlast), '0);
        chk("rst_m_data", m_tdata, '0);
        chk("rst_m_keep", MD'(m_tkeep), '0);

        // Full ascending packet.
        o0 = out_cnt;
        send(seq(8'h00), 8'hFF, 1'b0);
        send(seq(8'h08), 8'hFF, 1'b0);
        send(seq(8'h10), 8'hFF, 1'b0);
        send(seq(8'h18), 8'hFF, 1'b1);
        drain();
        chk("full_count", MD'(out_cnt - o0), MD'(1));

        // Short packet then a packet that must start at lane 0.
        send(seq(8'h40), 8'hFF, 1'b0);
        send(seq(8'h48), 8'hFF, 1'b1);
        send(seq(8'h50), 8'hFF, 1'b0);
        send(seq(8'h58), 8'hFF, 1'b0);
        send(seq(8'h60), 8'hFF, 1'b0);
        send(seq(8'h68), 8'hFF, 1'b1);
        drain();

        // Single-beat packet and partial keep at cnt 3.
        send(rnd_data(), 8'hFF, 1'b1);
        send(rnd_data(), 8'hFF, 1'b0);
        send(rnd_data(), 8'hFF, 1'b0);
        send(rnd_data(), 8'hFF, 1'b0);
        send(rnd_data(), 8'h0F, 1'b1);
        send(rnd_data(), 8'hA5, 1'b0);
        send(rnd_data(), 8'h3C, 1'b1);
        drain();

        // Backpressure: two groups, first output held for 5 cycles.
        o0 = out_cnt;
        m_tready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(seq(8'h80 + 8 * i), 8'hFF, 1'b0);
            end
            begin
                t = 0;
                while (!m_tvalid && t < 100) begin
                    @(posedge aclk);
                    t++;
                end
                #1;
                chk("bp_first_valid", MD'(m_tvalid), MD'(1'b1));
                repeat (5) @(posedge aclk);
                #1;
                m_tready = 1'b1;
            end
        join
        drain();
        chk("bp_count", MD'(out_cnt - o0), MD'(2));

        // Streaming at full rate.
        o0 = out_cnt;
        l0 = last_cnt;
        stall_waits = 0;
        for (int i = 0; i < 400; i++)
            send(rnd_data(), 8'(($urandom)), (i % 12) == 11);
        drain();
        chk("stream_count", MD'(out_cnt - o0), MD'(100));
        chk("stream_lasts", MD'(last_cnt - l0), MD'(33));
        chk("stream_stalls", MD'(stall_waits), '0);

        // Random ready, gaps, keep and tlast.
        rand_ready_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(rnd_data(), 8'($urandom), $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rand_ready_en = 1'b0;
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
        drain();
        if (grp.size() != 0) begin
            send(rnd_data(), 8'hFF, 1'b1);
            drain();
        end

        // Reset with an output pending.
        m_tready = 1'b0;
        send(rnd_data(), 8'hFF, 1'b1);
        chk("pend_valid", MD'(m_tvalid), MD'(1'b1));
        #2;
        areset = 1'b1;
        #1;
        chk("arst_valid", MD'(m_tvalid), '0);
        chk("arst_data", m_tdata, '0);
        chk("arst_keep", MD'(m_tkeep), '0);
        do_reset();
        m_tready = 1'b1;

        // Reset mid-group, then a clean group from lane 0.
        send(seq(8'hE0), 8'hFF, 1'b0);
        send(seq(8'hE8), 8'hFF, 1'b0);
        #2;
        areset = 1'b1;
        #1;
        chk("arst2_valid", MD'(m_tvalid), '0);
        do_reset();
        o0 = out_cnt;
        send(seq(8'h01), 8'hFF, 1'b0);
        send(seq(8'h11), 8'hFF, 1'b0);
        send(seq(8'h21), 8'hFF, 1'b0);
        send(seq(8'h31), 8'hFF, 1'b0);
        drain();
        chk("post_rst_count", MD'(out_cnt - o0), MD'(1));

        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
